// File: rtl/xbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// xbus_arbiter_if
// Signal bundle between the two bus masters (m0 = CPU, m1 = DMA/debug), the
// arbiter, and the decoder-facing data bus.
//   m0_*/m1_* : per-master request, lock, address, write enable, write data,
//               and the returned ack, error flag and read data.
//   bus_*     : selected transaction driven to the decoder, plus the decoder
//               read mux output and trap indication coming back.
// Modports:
//   slave  - arbiter side (takes master requests, drives the decoder bus)
//   master - environment side (masters and decoder)
// The address width comes from the ADDR_W macro (defaults to 16 bits).
// -----------------------------------------------------------------------------
`ifndef ADDR_W
`define ADDR_W 16
`endif

interface xbus_arbiter_if;
    logic                m0_req;
    logic                m0_lock;
    logic [`ADDR_W-1:0]  m0_addr;
    logic                m0_we;
    logic [31:0]         m0_data_to_wr;
    logic                m0_ack;
    logic                m0_err;
    logic [31:0]         m0_data_to_rd;

    logic                m1_req;
    logic                m1_lock;
    logic [`ADDR_W-1:0]  m1_addr;
    logic                m1_we;
    logic [31:0]         m1_data_to_wr;
    logic                m1_ack;
    logic                m1_err;
    logic [31:0]         m1_data_to_rd;

    logic                bus_sel;
    logic [`ADDR_W-1:0]  bus_addr;
    logic                bus_we;
    logic [31:0]         bus_data_to_wr;
    logic [31:0]         bus_data_to_rd;
    logic                bus_trap;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_we, m0_data_to_wr,
        output m0_ack, m0_err, m0_data_to_rd,
        input  m1_req, m1_lock, m1_addr, m1_we, m1_data_to_wr,
        output m1_ack, m1_err, m1_data_to_rd,
        output bus_sel, bus_addr, bus_we, bus_data_to_wr,
        input  bus_data_to_rd, bus_trap
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_we, m0_data_to_wr,
        input  m0_ack, m0_err, m0_data_to_rd,
        output m1_req, m1_lock, m1_addr, m1_we, m1_data_to_wr,
        input  m1_ack, m1_err, m1_data_to_rd,
        input  bus_sel, bus_addr, bus_we, bus_data_to_wr,
        output bus_data_to_rd, bus_trap
    );
endinterface

// File: rtl/xbus_arbiter.sv
// -----------------------------------------------------------------------------
// xbus_arbiter
// Two-master arbiter in front of the address decoder's single data-bus port.
// It runs one transaction at a time through a four-state sequence:
//   IDLE    : pick a winner and capture its address, write enable, data, lock
//   ISSUE   : bus_sel high for one cycle; sample the decoder trap
//   CAPTURE : sample the decoder read data
//   ACK     : one-cycle ack/err/data_to_rd to the winner
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   io   - xbus_arbiter_if.slave (master request/response and decoder bus)
// Parameter:
//   MAX_BURST (1..15) - longest locked burst before a forced re-arbitration
// Build option:
//   XARB_RR_EN - when defined, round-robin arbitration; otherwise fixed
//                priority with m0 ahead of m1.
// -----------------------------------------------------------------------------
`ifndef ADDR_W
`define ADDR_W 16
`endif

module xbus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    xbus_arbiter_if.slave     io
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t              state_reg;
    logic                winner_reg;      // 0 = m0, 1 = m1
    logic                cap_lock_reg;    // winner asked to keep the grant
    logic                trap_reg;        // decoder trap sampled during ISSUE
    logic                lock_held_reg;
    logic                lock_owner_reg;
    logic [3:0]          burst_cnt_reg;

    logic                bus_sel_reg;
    logic [`ADDR_W-1:0]  bus_addr_reg;
    logic                bus_we_reg;
    logic [31:0]         bus_data_to_wr_reg;

    logic [1:0]          ack_reg;
    logic [1:0]          err_reg;
    logic [31:0]         m0_data_to_rd_reg;
    logic [31:0]         m1_data_to_rd_reg;

    // ---------------------------------------------------------------------
    // Arbitration (combinational, only acted on in IDLE)
    // ---------------------------------------------------------------------
    logic owner_req;
    logic owner_lock;
    logic lock_active;
    logic elig0;
    logic elig1;
    logic grant;
    logic pick;

    assign owner_req   = lock_owner_reg ? io.m1_req  : io.m0_req;
    assign owner_lock  = lock_owner_reg ? io.m1_lock : io.m0_lock;
    // An owner that has dropped both req and lock gives the bus up in this
    // same IDLE cycle, so the other master may already win here.
    assign lock_active = lock_held_reg && (owner_req || owner_lock);

    assign elig0 = io.m0_req && (!lock_active || !lock_owner_reg);
    assign elig1 = io.m1_req && (!lock_active ||  lock_owner_reg);
    assign grant = elig0 || elig1;

`ifdef XARB_RR_EN
    logic rr_ptr_reg;     // master favoured on a tie
    assign pick = (elig0 && elig1) ? rr_ptr_reg : elig1;
`else
    assign pick = !elig0;
`endif

    // ---------------------------------------------------------------------
    // Sequencer with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            winner_reg         <= 1'b0;
            cap_lock_reg       <= 1'b0;
            trap_reg           <= 1'b0;
            lock_held_reg      <= 1'b0;
            lock_owner_reg     <= 1'b0;
            burst_cnt_reg      <= 4'd0;
            bus_sel_reg        <= 1'b0;
            bus_addr_reg       <= '0;
            bus_we_reg         <= 1'b0;
            bus_data_to_wr_reg <= 32'd0;
            ack_reg            <= 2'b00;
            err_reg            <= 2'b00;
            m0_data_to_rd_reg  <= 32'd0;
            m1_data_to_rd_reg  <= 32'd0;
`ifdef XARB_RR_EN
            rr_ptr_reg         <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (lock_held_reg && !lock_active) begin
                        lock_held_reg <= 1'b0;
                        burst_cnt_reg <= 4'd0;
                    end
                    if (grant) begin
                        // The bus registers double as the capture registers,
                        // so later changes on the master side never reach
                        // the decoder.
                        winner_reg         <= pick;
                        bus_sel_reg        <= 1'b1;
                        bus_addr_reg       <= pick ? io.m1_addr       : io.m0_addr;
                        bus_we_reg         <= pick ? io.m1_we         : io.m0_we;
                        bus_data_to_wr_reg <= pick ? io.m1_data_to_wr : io.m0_data_to_wr;
                        cap_lock_reg       <= pick ? io.m1_lock       : io.m0_lock;
`ifdef XARB_RR_EN
                        rr_ptr_reg         <= ~pick;
`endif
                        state_reg          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_sel_reg <= 1'b0;
                    trap_reg    <= io.bus_trap;
                    state_reg   <= CAPTURE;
                end
                CAPTURE: begin
                    ack_reg[winner_reg] <= 1'b1;
                    err_reg[winner_reg] <= trap_reg;
                    if (winner_reg)
                        m1_data_to_rd_reg <= io.bus_data_to_rd;
                    else
                        m0_data_to_rd_reg <= io.bus_data_to_rd;
                    state_reg <= ACK;
                end
                ACK: begin
                    ack_reg <= 2'b00;
                    err_reg <= 2'b00;
                    if (cap_lock_reg && (burst_cnt_reg < 4'(MAX_BURST - 1))) begin
                        lock_held_reg  <= 1'b1;
                        lock_owner_reg <= winner_reg;
                        burst_cnt_reg  <= burst_cnt_reg + 4'd1;
                    end else begin
                        lock_held_reg  <= 1'b0;
                        burst_cnt_reg  <= 4'd0;
                    end
                    // The req seen in this cycle belongs to the finished
                    // transaction; arbitration resumes in IDLE.
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io.bus_sel        = bus_sel_reg;
    assign io.bus_addr       = bus_addr_reg;
    assign io.bus_we         = bus_we_reg;
    assign io.bus_data_to_wr = bus_data_to_wr_reg;

    assign io.m0_ack         = ack_reg[0];
    assign io.m0_err         = err_reg[0];
    assign io.m0_data_to_rd  = m0_data_to_rd_reg;
    assign io.m1_ack         = ack_reg[1];
    assign io.m1_err         = err_reg[1];
    assign io.m1_data_to_rd  = m1_data_to_rd_reg;

endmodule

// File: tb/tb_xbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xbus_arbiter
// Directed bench for xbus_arbiter: reset values, single read, trapped write,
// continuous contention, locked burst, and reset mid-transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_xbus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    xbus_arbiter_if io ();

    xbus_arbiter #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for the next ack; who = -1 if none arrives within the budget.
    task automatic wait_ack(output int who);
        who = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (io.m0_ack) begin who = 0; break; end
            if (io.m1_ack) begin who = 1; break; end
        end
        $display("txn: grant m%0d", who);
    endtask

    int who;
    int exp_rr[4];

    initial begin
        rst               = 1'b1;
        io.m0_req         = 1'b0;
        io.m0_lock        = 1'b0;
        io.m0_addr        = '0;
        io.m0_we          = 1'b0;
        io.m0_data_to_wr  = 32'd0;
        io.m1_req         = 1'b0;
        io.m1_lock        = 1'b0;
        io.m1_addr        = '0;
        io.m1_we          = 1'b0;
        io.m1_data_to_wr  = 32'd0;
        io.bus_data_to_rd = 32'd0;
        io.bus_trap       = 1'b0;

        // ---------------- reset values ----------------
        do_reset();
        check("rst_bus_sel", 32'(io.bus_sel), 32'd0);
        check("rst_bus_we", 32'(io.bus_we), 32'd0);
        check("rst_bus_addr", 32'(io.bus_addr), 32'd0);
        check("rst_bus_wdata", io.bus_data_to_wr, 32'd0);
        check("rst_acks", {30'd0, io.m1_ack, io.m0_ack}, 32'd0);
        check("rst_errs", {30'd0, io.m1_err, io.m0_err}, 32'd0);
        check("rst_m0_rd", io.m0_data_to_rd, 32'd0);
        check("rst_m1_rd", io.m1_data_to_rd, 32'd0);

        // ---------------- single m0 read ----------------
        io.m0_req  = 1'b1;
        io.m0_addr = 'h10;
        io.m0_we   = 1'b0;
        check("rd_T_sel", 32'(io.bus_sel), 32'd0);
        tick();                                   // T+1
        check("rd_T1_sel", 32'(io.bus_sel), 32'd1);
        check("rd_T1_addr", 32'(io.bus_addr), 32'h10);
        check("rd_T1_we", 32'(io.bus_we), 32'd0);
        io.m0_addr = 'h77;                        // post-capture change must not leak
        tick();                                   // T+2
        check("rd_T2_sel", 32'(io.bus_sel), 32'd0);
        check("rd_T2_ack", 32'(io.m0_ack), 32'd0);
        check("rd_T2_addr_hold", 32'(io.bus_addr), 32'h10);
        io.bus_data_to_rd = 32'hDEADBEEF;
        tick();                                   // T+3
        io.bus_data_to_rd = 32'h0BADF00D;
        check("rd_T3_ack", 32'(io.m0_ack), 32'd1);
        check("rd_T3_data", io.m0_data_to_rd, 32'hDEADBEEF);
        check("rd_T3_err", 32'(io.m0_err), 32'd0);
        check("rd_T3_m1ack", 32'(io.m1_ack), 32'd0);
        $display("txn: m0 read 0x10 -> 0x%08h", io.m0_data_to_rd);
        io.m0_req = 1'b0;
        tick();
        check("rd_T4_ack", 32'(io.m0_ack), 32'd0);
        check("rd_T4_hold", io.m0_data_to_rd, 32'hDEADBEEF);

        // ---------------- m1 write with trap ----------------
        io.m1_req        = 1'b1;
        io.m1_addr       = 'h3FF0;
        io.m1_we         = 1'b1;
        io.m1_data_to_wr = 32'hA5A5A5A5;
        tick();                                   // T+1
        check("wr_T1_sel", 32'(io.bus_sel), 32'd1);
        check("wr_T1_we", 32'(io.bus_we), 32'd1);
        check("wr_T1_data", io.bus_data_to_wr, 32'hA5A5A5A5);
        io.bus_trap = 1'b1;
        tick();                                   // T+2
        io.bus_trap = 1'b0;
        tick();                                   // T+3
        check("wr_T3_ack", 32'(io.m1_ack), 32'd1);
        check("wr_T3_err", 32'(io.m1_err), 32'd1);
        check("wr_T3_m0ack", 32'(io.m0_ack), 32'd0);
        $display("txn: m1 write 0x3FF0 err=%0d", io.m1_err);
        io.m1_req = 1'b0;
        io.m1_we  = 1'b0;
        tick();
        check("wr_T4_err", 32'(io.m1_err), 32'd0);

        // ---------------- continuous contention ----------------
        do_reset();
`ifdef XARB_RR_EN
        exp_rr = '{0, 1, 0, 1};
`else
        exp_rr = '{0, 0, 0, 0};
`endif
        io.m0_req = 1'b1;
        io.m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who);
            check($sformatf("contend_%0d", i), 32'(who), 32'(exp_rr[i]));
        end
        io.m0_req = 1'b0;
        io.m1_req = 1'b0;

        // ---------------- locked burst ----------------
        do_reset();
        io.m1_req  = 1'b1;
        io.m1_lock = 1'b1;
        tick();                                   // m1 granted alone
        io.m0_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_ack(who);
            check($sformatf("lock_%0d", i), 32'(who), (i < 4) ? 32'd1 : 32'd0);
        end
        io.m0_req  = 1'b0;
        io.m1_req  = 1'b0;
        io.m1_lock = 1'b0;

        // ---------------- reset during CAPTURE ----------------
        do_reset();
        io.m0_req  = 1'b1;
        io.m0_addr = 'h20;
        tick();                                   // ISSUE
        tick();                                   // CAPTURE
        io.bus_data_to_rd = 32'h11111111;
        rst = 1'b1;
        tick();                                   // back in IDLE
        rst = 1'b0;
        check("rstc_ack", 32'(io.m0_ack), 32'd0);
        check("rstc_sel", 32'(io.bus_sel), 32'd0);
        check("rstc_addr", 32'(io.bus_addr), 32'd0);
        check("rstc_rd", io.m0_data_to_rd, 32'd0);
        tick();                                   // held req re-issued
        check("rstc_reissue_sel", 32'(io.bus_sel), 32'd1);
        check("rstc_reissue_addr", 32'(io.bus_addr), 32'h20);
        tick();
        io.bus_data_to_rd = 32'h12345678;
        tick();
        check("rstc_ack2", 32'(io.m0_ack), 32'd1);
        check("rstc_data2", io.m0_data_to_rd, 32'h12345678);
        $display("txn: m0 reissue 0x20 -> 0x%08h", io.m0_data_to_rd);
        io.m0_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
